// File: rtl/axi_write_slave.sv
// axi_write_slave
//   AXI4 write-channel responder. Accepts one AW burst at a time, turns each
//   W beat into a byte-strobed write on a simple SRAM-style port, and returns
//   one B response per burst.
//
// Ports
//   clk, resetn                       clock, asynchronous active-low reset
//   axi_aw{addr,len,size,burst}       write address channel payload
//   axi_awvalid / axi_awready         address handshake
//   axi_w{data,strb,last}             write data channel payload
//   axi_wvalid / axi_wready           data handshake
//   axi_bresp, axi_bvalid, axi_bready write response channel
//   mem_we, mem_addr, mem_wdata,      memory write port; mem_we is a one-cycle
//   mem_wstrb                         pulse per accepted, error-free beat
module axi_write_slave #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 64,
    parameter int unsigned MAX_SIZE = 3
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [AW-1:0]   axi_awaddr,
    input  logic [7:0]      axi_awlen,
    input  logic [2:0]      axi_awsize,
    input  logic [1:0]      axi_awburst,
    input  logic            axi_awvalid,
    output logic            axi_awready,
    input  logic [DW-1:0]   axi_wdata,
    input  logic [DW/8-1:0] axi_wstrb,
    input  logic            axi_wlast,
    input  logic            axi_wvalid,
    output logic            axi_wready,
    output logic [1:0]      axi_bresp,
    output logic            axi_bvalid,
    input  logic            axi_bready,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb
);

    typedef enum logic [1:0] {StInit, StIdle, StData, StResp} state_e;

    localparam logic [1:0] BurstIncr = 2'b01;
    localparam logic [1:0] RespOkay  = 2'b00;
    localparam logic [1:0] RespSlv   = 2'b10;

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    len_q;
    logic [7:0]    cnt_q;
    logic [2:0]    size_q;
    logic [1:0]    burst_q;
    logic          err_q;

    logic          aw_hs;
    logic          w_hs;
    logic          len_hit;
    logic          burst_done;
    logic          last_err;
    logic          aw_err;
    logic [AW-1:0] addr_step;

    assign aw_hs      = axi_awvalid & axi_awready;
    assign w_hs       = axi_wvalid & axi_wready;
    assign len_hit    = (cnt_q == len_q);
    // A burst ends on the expected final beat or on an early wlast.
    assign burst_done = w_hs & (len_hit | axi_wlast);
    // wlast must coincide exactly with the final beat.
    assign last_err   = len_hit ^ axi_wlast;
    // WRAP and reserved bursts, and oversize beats, are unsupported.
    assign aw_err     = axi_awburst[1] | (32'(axi_awsize) > MAX_SIZE);
    assign addr_step  = AW'(1) << size_q;

    // A beat is written only if no error was flagged before it.
    assign mem_we     = w_hs & ~err_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = axi_wdata;
    assign mem_wstrb  = axi_wstrb;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StInit;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            err_q       <= 1'b0;
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b0;
            axi_bresp   <= RespOkay;
        end else begin
            unique case (state_q)
                StInit: begin
                    state_q     <= StIdle;
                    axi_awready <= 1'b1;
                end
                StIdle: begin
                    if (aw_hs) begin
                        addr_q      <= axi_awaddr;
                        len_q       <= axi_awlen;
                        size_q      <= axi_awsize;
                        burst_q     <= axi_awburst;
                        cnt_q       <= '0;
                        err_q       <= aw_err;
                        state_q     <= StData;
                        axi_awready <= 1'b0;
                        axi_wready  <= 1'b1;
                    end
                end
                StData: begin
                    if (w_hs) begin
                        cnt_q <= cnt_q + 8'd1;
                        // FIXED holds the address; only INCR advances it.
                        if (burst_q == BurstIncr) begin
                            addr_q <= addr_q + addr_step;
                        end
                        if (burst_done) begin
                            err_q      <= err_q | last_err;
                            axi_bresp  <= (err_q | last_err) ? RespSlv : RespOkay;
                            state_q    <= StResp;
                            axi_wready <= 1'b0;
                            axi_bvalid <= 1'b1;
                        end
                    end
                end
                StResp: begin
                    if (axi_bvalid && axi_bready) begin
                        err_q       <= 1'b0;
                        axi_bresp   <= RespOkay;
                        state_q     <= StIdle;
                        axi_bvalid  <= 1'b0;
                        axi_awready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_slave.sv
// Directed testbench for axi_write_slave. Inputs change and outputs are
// sampled just after the falling edge; the DUT acts on the rising edge.
module tb_axi_write_slave;

    logic        clk;
    logic        resetn;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [63:0] axi_wdata;
    logic [7:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;

    int n_checks = 0;
    int n_fail   = 0;

    axi_write_slave #(.AW(32), .DW(64), .MAX_SIZE(3)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_awsize  (axi_awsize),
        .axi_awburst (axi_awburst),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wlast   (axi_wlast),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_aw(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        @(negedge clk);
        axi_awaddr  = addr;
        axi_awlen   = len;
        axi_awsize  = size;
        axi_awburst = burst;
        axi_awvalid = 1'b1;
        #1;
        chk("aw_ready", 64'(axi_awready), 64'd1);
        @(posedge clk);
        #1;
        axi_awvalid = 1'b0;
    endtask

    task automatic do_beat(input string tag, input logic [63:0] data, input logic [7:0] strb,
                           input logic last, input logic exp_we, input logic [31:0] exp_addr);
        @(negedge clk);
        axi_wdata  = data;
        axi_wstrb  = strb;
        axi_wlast  = last;
        axi_wvalid = 1'b1;
        #1;
        chk({tag, "_wready"}, 64'(axi_wready), 64'd1);
        chk({tag, "_we"}, 64'(mem_we), 64'(exp_we));
        if (exp_we) begin
            chk({tag, "_addr"}, 64'(mem_addr), 64'(exp_addr));
            chk({tag, "_wdata"}, mem_wdata, data);
            chk({tag, "_wstrb"}, 64'(mem_wstrb), 64'(strb));
        end
        @(posedge clk);
        #1;
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
    endtask

    // Expects bready already high: B completes in the first RESP cycle.
    task automatic do_resp(input string tag, input logic [1:0] exp_resp);
        @(negedge clk);
        #1;
        chk({tag, "_wready_low"}, 64'(axi_wready), 64'd0);
        chk({tag, "_awready_low"}, 64'(axi_awready), 64'd0);
        chk({tag, "_bvalid"}, 64'(axi_bvalid), 64'd1);
        chk({tag, "_bresp"}, 64'(axi_bresp), 64'(exp_resp));
        @(negedge clk);
        #1;
        chk({tag, "_bvalid_drop"}, 64'(axi_bvalid), 64'd0);
        chk({tag, "_awready_back"}, 64'(axi_awready), 64'd1);
    endtask

    initial begin
        resetn      = 1'b0;
        axi_awaddr  = '0;
        axi_awlen   = '0;
        axi_awsize  = '0;
        axi_awburst = '0;
        axi_awvalid = 1'b0;
        axi_wdata   = '0;
        axi_wstrb   = '0;
        axi_wlast   = 1'b0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b1;

        // Reset values
        #3;
        chk("rst_awready", 64'(axi_awready), 64'd0);
        chk("rst_wready", 64'(axi_wready), 64'd0);
        chk("rst_bvalid", 64'(axi_bvalid), 64'd0);
        chk("rst_bresp", 64'(axi_bresp), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("init_awready", 64'(axi_awready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("idle_awready", 64'(axi_awready), 64'd1);

        // 1: INCR 4 x 8 bytes from 0x1000
        do_aw(32'h0000_1000, 8'd3, 3'd3, 2'b01);
        do_beat("t1b1", 64'h1111_0000_0000_0001, 8'hFF, 1'b0, 1'b1, 32'h0000_1000);
        do_beat("t1b2", 64'h1111_0000_0000_0002, 8'hFF, 1'b0, 1'b1, 32'h0000_1008);
        do_beat("t1b3", 64'h1111_0000_0000_0003, 8'hF0, 1'b0, 1'b1, 32'h0000_1010);
        do_beat("t1b4", 64'h1111_0000_0000_0004, 8'h0F, 1'b1, 1'b1, 32'h0000_1018);
        do_resp("t1", 2'b00);

        // W presented in IDLE is not accepted
        @(negedge clk);
        axi_wvalid = 1'b1;
        #1;
        chk("idle_wready", 64'(axi_wready), 64'd0);
        chk("idle_we", 64'(mem_we), 64'd0);
        @(posedge clk);
        #1;
        axi_wvalid = 1'b0;

        // 2: FIXED, two beats to 0x2000, 4-byte strobes
        do_aw(32'h0000_2000, 8'd1, 3'd2, 2'b00);
        do_beat("t2b1", 64'h0000_0000_AAAA_0001, 8'h0F, 1'b0, 1'b1, 32'h0000_2000);
        do_beat("t2b2", 64'h0000_0000_AAAA_0002, 8'h0F, 1'b1, 1'b1, 32'h0000_2000);
        do_resp("t2", 2'b00);

        // 3: early wlast on beat 2 of 4
        do_aw(32'h0000_3000, 8'd3, 3'd3, 2'b01);
        do_beat("t3b1", 64'h3333_0000_0000_0001, 8'hFF, 1'b0, 1'b1, 32'h0000_3000);
        do_beat("t3b2", 64'h3333_0000_0000_0002, 8'hFF, 1'b1, 1'b1, 32'h0000_3008);
        do_resp("t3", 2'b10);

        // 4a: WRAP burst is accepted but never written
        do_aw(32'h0000_4000, 8'd1, 3'd3, 2'b10);
        do_beat("t4ab1", 64'h4444_0000_0000_0001, 8'hFF, 1'b0, 1'b0, 32'h0);
        do_beat("t4ab2", 64'h4444_0000_0000_0002, 8'hFF, 1'b1, 1'b0, 32'h0);
        do_resp("t4a", 2'b10);

        // 4b: oversize beat is accepted but never written
        do_aw(32'h0000_4100, 8'd1, 3'd4, 2'b01);
        do_beat("t4bb1", 64'h4444_0000_0000_0003, 8'hFF, 1'b0, 1'b0, 32'h0);
        do_beat("t4bb2", 64'h4444_0000_0000_0004, 8'hFF, 1'b1, 1'b0, 32'h0);
        do_resp("t4b", 2'b10);

        // 5: B back-pressure with a new AW waiting
        do_aw(32'h0000_5000, 8'd0, 3'd3, 2'b01);
        axi_bready = 1'b0;
        do_beat("t5b1", 64'h5555_0000_0000_0001, 8'hFF, 1'b1, 1'b1, 32'h0000_5000);
        axi_awaddr  = 32'h0000_5100;
        axi_awlen   = 8'd0;
        axi_awsize  = 3'd3;
        axi_awburst = 2'b01;
        axi_awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("t5_hold_bvalid", 64'(axi_bvalid), 64'd1);
            chk("t5_hold_bresp", 64'(axi_bresp), 64'd0);
            chk("t5_hold_awready", 64'(axi_awready), 64'd0);
        end
        @(negedge clk);
        axi_bready = 1'b1;
        #1;
        chk("t5_bvalid_last", 64'(axi_bvalid), 64'd1);
        chk("t5_awready_wait", 64'(axi_awready), 64'd0);
        @(negedge clk);
        #1;
        chk("t5_bvalid_done", 64'(axi_bvalid), 64'd0);
        chk("t5_awready_new", 64'(axi_awready), 64'd1);
        @(posedge clk);
        #1;
        axi_awvalid = 1'b0;
        do_beat("t5c1", 64'h5555_0000_0000_0002, 8'h3C, 1'b1, 1'b1, 32'h0000_5100);
        do_resp("t5c", 2'b00);

        // 6: reset in the middle of a 4-beat burst
        do_aw(32'h0000_6000, 8'd3, 3'd3, 2'b01);
        do_beat("t6b1", 64'h6666_0000_0000_0001, 8'hFF, 1'b0, 1'b1, 32'h0000_6000);
        do_beat("t6b2", 64'h6666_0000_0000_0002, 8'hFF, 1'b0, 1'b1, 32'h0000_6008);
        @(negedge clk);
        axi_wvalid = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        chk("t6_rst_awready", 64'(axi_awready), 64'd0);
        chk("t6_rst_wready", 64'(axi_wready), 64'd0);
        chk("t6_rst_bvalid", 64'(axi_bvalid), 64'd0);
        chk("t6_rst_bresp", 64'(axi_bresp), 64'd0);
        chk("t6_rst_we", 64'(mem_we), 64'd0);
        axi_wvalid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("t6_rel_awready", 64'(axi_awready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t6_idle_awready", 64'(axi_awready), 64'd1);
        chk("t6_no_bvalid", 64'(axi_bvalid), 64'd0);

        // 7: INCR address wraps modulo 2^32, with a stalled cycle between beats
        do_aw(32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01);
        do_beat("t7b1", 64'h7777_0000_0000_0001, 8'hFF, 1'b0, 1'b1, 32'hFFFF_FFF8);
        @(negedge clk);
        #1;
        chk("t7_stall_we", 64'(mem_we), 64'd0);
        chk("t7_stall_addr", 64'(mem_addr), 64'h0);
        do_beat("t7b2", 64'h7777_0000_0000_0002, 8'hFF, 1'b1, 1'b1, 32'h0000_0000);
        do_resp("t7", 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_write_slave.md
Name: axi_write_slave

Overview:
- AXI4 write-channel responder: the slave end of the write path that the master FSM and the Write_Channel model drive.
- Accepts one AW burst at a time, then its W beats, and converts each beat into a byte-strobed write on a simple SRAM-style memory port.
- Returns one B response per burst.
- Used as the bench-side responder for master-side equivalence checks and as a standalone memory-backed slave.

Parameters:
- AW, 32, address width.
- DW, 64, data width; must be 64 in this revision, so STRB = DW/8 = 8.
- MAX_SIZE, 3, largest legal awsize (log2 of DW/8).

Ports:
- clk  in  1  global clock.
- resetn  in  1  asynchronous active-low reset.
- axi_awaddr  in  AW  burst start address.
- axi_awlen  in  8  beats minus 1.
- axi_awsize  in  3  log2 bytes per beat.
- axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- axi_awvalid  in  1  address valid.
- axi_awready  out  1  address accepted.
- axi_wdata  in  DW  write data.
- axi_wstrb  in  DW/8  byte strobes.
- axi_wlast  in  1  last beat marker.
- axi_wvalid  in  1  data valid.
- axi_wready  out  1  data accepted.
- axi_bresp  out  2  00 OKAY, 10 SLVERR.
- axi_bvalid  out  1  response valid.
- axi_bready  in  1  master accepts response.
- mem_we  out  1  memory write enable, one cycle per accepted beat.
- mem_addr  out  AW  byte address of the current beat.
- mem_wdata  out  DW  equals axi_wdata.
- mem_wstrb  out  DW/8  equals axi_wstrb.

Behaviour:
- Reset (resetn=0, asynchronous):
  - State INIT.
  - axi_awready=0, axi_wready=0, axi_bvalid=0, axi_bresp=00, mem_we=0.
  - Beat counter 0, address register 0, error flag 0.
- States:
  - INIT: one cycle after reset release, then IDLE.
  - IDLE: awready=1.
  - DATA: wready=1.
  - RESP: bvalid=1.
- Registered outputs: awready, wready and bvalid are all registered, decoded from next-state.
- IDLE:
  - On awvalid&awready, latch awaddr, awlen, awsize and awburst; clear the beat counter; go to DATA next cycle.
  - W beats presented while in IDLE are not accepted (wready=0).
- Error flag set at AW acceptance if awburst==10 or 11, or awsize>MAX_SIZE. In that case all beats are still accepted and mem_we is held 0 for the whole burst.
- DATA, on each wvalid&wready:
  - mem_we=1 combinationally in the same cycle unless the error flag is set.
  - mem_addr = current address register.
  - mem_wdata and mem_wstrb pass through from the W channel.
  - Beat counter increments.
  - Address update: FIXED holds the address; INCR adds (1<<awsize) modulo 2^AW. No 4 KB boundary check.
- wlast checking:
  - Beat count==awlen with wlast=1: burst complete, go to RESP.
  - Beat count==awlen with wlast=0: set error, go to RESP.
  - wlast=1 with beat count<awlen: set error, go to RESP. That beat is still written if there is no prior error; later beats of the burst are not accepted.
- RESP:
  - bresp = SLVERR if the error flag is set, else OKAY.
  - bvalid held with bresp stable until bready.
  - On bvalid&bready: next cycle go to IDLE, bvalid=0, clear the error flag.
  - bready already high on the first RESP cycle completes the handshake in that cycle.
- Simultaneous events:
  - awvalid during DATA or RESP waits (awready=0). Exactly one outstanding burst.
  - Minimum burst turnaround: AW cycle, N beat cycles, 1 B cycle, then IDLE again.
- awlen=0: a single beat; wlast must be 1 on it.
- Reset mid-burst: immediate return to INIT with all outputs at their reset values. The partial burst is dropped with no B response.
- wvalid low in DATA: the block stalls; no counter or address change.

Test Plan:
- Reset, then INCR awaddr=0x1000, awlen=3, awsize=3, four beats with wlast on beat 4 and bready=1 -> mem_we pulses at 0x1000, 0x1008, 0x1010, 0x1018; bresp=00; bvalid for 1 cycle.
- FIXED awaddr=0x2000, awlen=1, awsize=2, wstrb=0x0F -> two writes both to 0x2000 with mem_wstrb=0x0F; bresp=00.
- INCR awlen=3, wlast asserted on beat 2 -> writes on beats 1 and 2 only; wready drops; bresp=10.
- awburst=10 (WRAP), awlen=1 -> two beats accepted, mem_we never 1, bresp=10. Also awsize=4 -> same result.
- bready held 0 for 5 cycles after the last beat, new awvalid presented -> bvalid and bresp stable; awready=0 until 1 cycle after B completes.
- resetn dropped after beat 2 of a 4-beat burst, then released -> all outputs 0 asynchronously; awready=1 on the second clock after release; no bvalid.
- INCR awaddr=0xFFFFFFF8, awlen=1, awsize=3 -> writes to 0xFFFFFFF8, then 0x00000000.
